sw_array_ctrl: RTL and testbench
================================

# sw_array_ctrl

Sequencer for a linear Smith-Waterman systolic array of `NUM_PE` affine-gap PEs.
- Loads one query symbol into each PE from a query memory.
- Streams the reference sequence from a reference memory into PE0 as a contiguous, bubble-free burst. The PEs have no stall, so gaps are not allowed.
- Tracks the best score emerging from the last PE, i.e. the best alignment ending at the query end, and the reference position where that score occurs.
- Sits between the host/job logic and the PE chain.

## Interface
Parameters:
- `NUM_PE`, 16: PEs in the array, which is also the query length.
- `WIDTH`, 10: score width; matches the PE score width; signed two's complement.
- `LEN_W`, 16: width of reference length and reference address.
- `Q_ADDR_W`, `$clog2(NUM_PE)`: query address width.

Ports (one clock; reset is synchronous and active-high):
- `clk`  in  1  system clock
- `rst`  in  1  synchronous active-high reset
- `start`  in  1  begin a job; sampled only in IDLE
- `ref_len`  in  LEN_W  reference length L; latched when `start` is accepted
- `q_rd_en` / `q_addr`  out  1 / Q_ADDR_W  query memory read; data returns 1 cycle later
- `q_data`  in  2  query symbol
- `ref_rd_en` / `ref_addr`  out  1 / LEN_W  reference memory read; data returns 1 cycle later
- `ref_data`  in  2  reference symbol
- `s_data`  out  2  query symbol broadcast to the `S_in` of every PE
- `store_s_en`  out  NUM_PE  one-hot per-PE `store_S_in`
- `t_in`  out  2  `T_in` of PE0
- `init_in`  out  1  `init_in` of PE0
- `v_last`  in  WIDTH  `V_out` of PE NUM_PE-1
- `init_last`  in  1  `init_out` of PE NUM_PE-1
- `busy`  out  1  high in every state except IDLE
- `done`  out  1  one-cycle pulse; result is valid from this cycle
- `best_score`  out  WIDTH  held until the next accepted `start`
- `best_pos`  out  LEN_W  0-based reference index of the first maximum

## Operation
FSM states: IDLE, LOAD_Q, STREAM, DRAIN, DONE.
- **IDLE:** on `start`:
  - `ref_len`≠0: latch L, clear the tracker to score 0 and pos 0, go to LOAD_Q.
  - `ref_len`==0: go to DONE with score 0 and pos 0.
- **LOAD_Q:** NUM_PE cycles.
  - Cycle i asserts `q_rd_en` with `q_addr`=i.
  - The next cycle drives `s_data`=`q_data` and `store_s_en`=1<<i, so PE i holds query[i].
- **STREAM:** L cycles.
  - Cycle j asserts `ref_rd_en` with `ref_addr`=j.
  - `init_in` is `ref_rd_en` delayed by one register.
  - `t_in`=`ref_data` while `init_in`=1, otherwise 0.
- **DRAIN:** counter-terminated. Ends on the cycle the last expected sample is taken, which is when the sample counter reaches L.
- **DONE:** pulse `done` for one cycle, then return to IDLE.

Score tracker:
- Every cycle with `init_last`=1 is one sample with index k = 0..L-1.
- If `$signed(v_last)` is strictly greater than `best_score`, set `best_score`=`v_last` and `best_pos`=k.
- Ties keep the earlier position.

Other rules:
- `start` while `busy`: ignored.
- Reset at any point, including mid-job: FSM goes to IDLE. The array is not flushed by this block; the PEs share `rst`.

## Timing
Take cycle 0 as the edge that samples `start`. N is NUM_PE.
- LOAD_Q reads: cycles 1..N. Query writes: cycles 2..N+1.
- STREAM reads: cycles N+1..N+L. `init_in` high: cycles N+2..N+L+1.
- `init_last` high: cycles 2N+2..2N+L+1.
- `done` high: cycle 2N+L+2.
- `ref_len`=0: `done` high at cycle 1.
- Reset value of every output is 0: `q_rd_en`, `q_addr`, `ref_rd_en`, `ref_addr`, `s_data`, `store_s_en`, `t_in`, `init_in`, `busy`, `done`, `best_score`, `best_pos`.
- `store_s_en` is 0 outside the write cycles. At most one bit is set in any cycle.
- The last query write and the first reference read share cycle N+1; they use independent ports.
- `init_in` never drops between its first and last cycle. The stream is contiguous.

## Structure
- Shared package `sw_pkg`:
  - 2-bit symbol type with encoding A=0, C=1, G=2, T=3.
  - FSM state enum.
  - Scoring constants shared with the PE: match +2, mismatch -2, gap open -2, gap extend -1.
  - Default `WIDTH`.
- Sub-module `sw_score_tracker`: signed max/argmax register with clear, sample-valid input and sample counter.

## Test plan
All scenarios use NUM_PE=4 and a behavioural PE array model.
- Query ACGT, ref ACGT (L=4) -> `best_score`=8, `best_pos`=3, `done` at cycle 14.
- Query ACGT, ref TTACGTAA (L=8) -> `best_score`=8, `best_pos`=5, `done` at cycle 18, `init_in` contiguous over cycles 6..13.
- Query AAAA, ref CCCCCC -> `best_score`=0, `best_pos`=0.
- `ref_len`=0 -> `done` at cycle 1, score 0, no memory reads issued.
- `rst` asserted at cycle 8 of an L=8 job -> all outputs 0 on the next cycle; a following job with query ACGT, ref ACGT gives 8 at pos 3.
- `start` pulsed in cycles 3 and 10 of a running job -> ignored; exactly one `done`, with an unchanged result.

Source files
------------

// File: rtl/sw_pkg.sv
// Shared types and scoring constants for the Smith-Waterman PE array and its sequencer.
package sw_pkg;

  typedef enum logic [1:0] {
    SYM_A = 2'd0,
    SYM_C = 2'd1,
    SYM_G = 2'd2,
    SYM_T = 2'd3
  } sym_t;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LOAD_Q,
    ST_STREAM,
    ST_DRAIN,
    ST_DONE
  } state_t;

  localparam int MATCH_SCORE    = 2;
  localparam int MISMATCH_SCORE = -2;
  localparam int GAP_OPEN       = -2;
  localparam int GAP_EXTEND     = -1;
  localparam int DEFAULT_WIDTH  = 10;

  // Substitution score as applied inside each PE.
  function automatic int sub_score(input sym_t a, input sym_t b);
    return (a == b) ? MATCH_SCORE : MISMATCH_SCORE;
  endfunction

endpackage

// File: rtl/sw_array_ctrl_if.sv
// Job, memory and PE-chain signals of the array sequencer; master is the sequencer side.
interface sw_array_ctrl_if #(
  parameter int NUM_PE   = 16,
  parameter int WIDTH    = sw_pkg::DEFAULT_WIDTH,
  parameter int LEN_W    = 16,
  parameter int Q_ADDR_W = $clog2(NUM_PE)
);
  import sw_pkg::*;

  logic                start;
  logic [LEN_W-1:0]    ref_len;
  logic                q_rd_en;
  logic [Q_ADDR_W-1:0] q_addr;
  sym_t                q_data;
  logic                ref_rd_en;
  logic [LEN_W-1:0]    ref_addr;
  sym_t                ref_data;
  sym_t                s_data;
  logic [NUM_PE-1:0]   store_s_en;
  sym_t                t_in;
  logic                init_in;
  logic [WIDTH-1:0]    v_last;
  logic                init_last;
  logic                busy;
  logic                done;
  logic [WIDTH-1:0]    best_score;
  logic [LEN_W-1:0]    best_pos;

  modport master (
    input  start, ref_len, q_data, ref_data, v_last, init_last,
    output q_rd_en, q_addr, ref_rd_en, ref_addr, s_data, store_s_en,
           t_in, init_in, busy, done, best_score, best_pos
  );

  modport slave (
    output start, ref_len, q_data, ref_data, v_last, init_last,
    input  q_rd_en, q_addr, ref_rd_en, ref_addr, s_data, store_s_en,
           t_in, init_in, busy, done, best_score, best_pos
  );

endinterface

// File: rtl/sw_score_tracker.sv
// Signed running max/argmax over the last-PE score stream; ties keep the earlier index.
module sw_score_tracker #(
  parameter int WIDTH = sw_pkg::DEFAULT_WIDTH,
  parameter int LEN_W = 16
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    clear,
  input  logic                    sample_vld,
  input  logic signed [WIDTH-1:0] sample,
  output logic signed [WIDTH-1:0] best_score,
  output logic        [LEN_W-1:0] best_pos,
  output logic        [LEN_W-1:0] sample_cnt
);

  // Starting from zero means an all-negative column never displaces position 0.
  always_ff @(posedge clk) begin
    if (rst || clear) begin
      best_score <= '0;
      best_pos   <= '0;
      sample_cnt <= '0;
    end else if (sample_vld) begin
      if (sample > best_score) begin
        best_score <= sample;
        best_pos   <= sample_cnt;
      end
      sample_cnt <= sample_cnt + LEN_W'(1);
    end
  end

endmodule

// File: rtl/sw_array_ctrl.sv
// Sequencer for a linear affine-gap Smith-Waterman systolic array: query load,
// bubble-free reference stream, and best-score tracking at the query end.
module sw_array_ctrl
  import sw_pkg::*;
#(
  parameter int NUM_PE   = 16,
  parameter int WIDTH    = DEFAULT_WIDTH,
  parameter int LEN_W    = 16,
  parameter int Q_ADDR_W = $clog2(NUM_PE)
) (
  input logic            clk,
  input logic            rst,
  sw_array_ctrl_if.master bus
);

  localparam logic [LEN_W-1:0] LAST_Q = LEN_W'(NUM_PE - 1);

  state_t              state;
  state_t              state_nxt;
  logic [LEN_W-1:0]    cnt;
  logic [LEN_W-1:0]    len;
  logic                q_vld_d;
  logic [Q_ADDR_W-1:0] q_idx_d;
  logic                init_d;
  logic                clear;
  logic                sample_vld;
  logic [LEN_W-1:0]    sample_cnt;
  logic signed [WIDTH-1:0] trk_score;
  logic [LEN_W-1:0]    trk_pos;

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // One counter walks the query index in LOAD_Q and the reference index in STREAM.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt <= '0;
      len <= '0;
    end else begin
      unique case (state)
        ST_IDLE: begin
          cnt <= '0;
          if (bus.start) begin
            len <= bus.ref_len;
          end
        end
        ST_LOAD_Q: cnt <= (cnt == LAST_Q) ? '0 : cnt + LEN_W'(1);
        ST_STREAM: cnt <= cnt + LEN_W'(1);
        default:   cnt <= '0;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      q_vld_d <= 1'b0;
      q_idx_d <= '0;
      init_d  <= 1'b0;
    end else begin
      q_vld_d <= bus.q_rd_en;
      q_idx_d <= bus.q_addr;
      init_d  <= bus.ref_rd_en;
    end
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      ST_IDLE: begin
        if (bus.start) begin
          state_nxt = (bus.ref_len == '0) ? ST_DONE : ST_LOAD_Q;
        end
      end
      ST_LOAD_Q: begin
        if (cnt == LAST_Q) begin
          state_nxt = ST_STREAM;
        end
      end
      ST_STREAM: begin
        if (cnt == len - LEN_W'(1)) begin
          state_nxt = ST_DRAIN;
        end
      end
      // The PE chain has no end marker, so drain until the L-th sample is taken.
      ST_DRAIN: begin
        if (sample_vld && (sample_cnt == len - LEN_W'(1))) begin
          state_nxt = ST_DONE;
        end
      end
      ST_DONE: state_nxt = ST_IDLE;
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_comb begin
    bus.q_rd_en    = 1'b0;
    bus.q_addr     = '0;
    bus.ref_rd_en  = 1'b0;
    bus.ref_addr   = '0;
    bus.busy       = (state != ST_IDLE);
    bus.done       = (state == ST_DONE);
    clear          = (state == ST_IDLE) && bus.start;
    sample_vld     = bus.init_last && ((state == ST_STREAM) || (state == ST_DRAIN));
    if (state == ST_LOAD_Q) begin
      bus.q_rd_en = 1'b1;
      bus.q_addr  = cnt[Q_ADDR_W-1:0];
    end
    if (state == ST_STREAM) begin
      bus.ref_rd_en = 1'b1;
      bus.ref_addr  = cnt;
    end
    // Symbol buses are forced to zero outside their valid cycles.
    bus.s_data     = q_vld_d ? bus.q_data : SYM_A;
    bus.store_s_en = q_vld_d ? (NUM_PE'(1) << q_idx_d) : '0;
    bus.init_in    = init_d;
    bus.t_in       = init_d ? bus.ref_data : SYM_A;
    bus.best_score = trk_score;
    bus.best_pos   = trk_pos;
  end

  sw_score_tracker #(
    .WIDTH (WIDTH),
    .LEN_W (LEN_W)
  ) u_tracker (
    .clk        (clk),
    .rst        (rst),
    .clear      (clear),
    .sample_vld (sample_vld),
    .sample     (bus.v_last),
    .best_score (trk_score),
    .best_pos   (trk_pos),
    .sample_cnt (sample_cnt)
  );

endmodule

// File: tb/tb_sw_array_ctrl.sv
// Self-checking bench for sw_array_ctrl: memories, a behavioural PE chain and a DP reference model.
module tb_sw_array_ctrl;
  import sw_pkg::*;

  localparam int NUM_PE = 4;
  localparam int WIDTH  = 10;
  localparam int LEN_W  = 16;
  localparam int MAX_L  = 32;
  localparam int NEG    = -1000;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_vec = 0;
  int   n_err = 0;

  sym_t qmem [NUM_PE];
  sym_t rmem [MAX_L];

  sw_array_ctrl_if #(.NUM_PE(NUM_PE), .WIDTH(WIDTH), .LEN_W(LEN_W)) bus ();

  sw_array_ctrl #(.NUM_PE(NUM_PE), .WIDTH(WIDTH), .LEN_W(LEN_W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  function automatic int max2(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

  // Local affine-gap DP; returns H at the last query row for reference column k.
  function automatic int last_row_score(input sym_t q [NUM_PE], input sym_t r [MAX_L], input int k);
    int h [NUM_PE+1][MAX_L+1];
    int e [NUM_PE+1][MAX_L+1];
    int f [NUM_PE+1][MAX_L+1];
    for (int i = 0; i <= NUM_PE; i++) begin
      for (int j = 0; j <= MAX_L; j++) begin
        h[i][j] = 0;
        e[i][j] = NEG;
        f[i][j] = NEG;
      end
    end
    for (int j = 1; j <= k + 1; j++) begin
      for (int i = 1; i <= NUM_PE; i++) begin
        e[i][j] = max2(h[i][j-1] + GAP_OPEN, e[i][j-1] + GAP_EXTEND);
        f[i][j] = max2(h[i-1][j] + GAP_OPEN, f[i-1][j] + GAP_EXTEND);
        h[i][j] = max2(max2(0, h[i-1][j-1] + sub_score(q[i-1], r[j-1])), max2(e[i][j], f[i][j]));
      end
    end
    return h[NUM_PE][k+1];
  endfunction

  function automatic sym_t to_sym(input byte ch);
    case (ch)
      "C":     return SYM_C;
      "G":     return SYM_G;
      "T":     return SYM_T;
      default: return SYM_A;
    endcase
  endfunction

  // Memories with one cycle of read latency.
  always @(posedge clk) begin
    if (bus.q_rd_en) bus.q_data <= qmem[int'(bus.q_addr)];
    if (bus.ref_rd_en) bus.ref_data <= (int'(bus.ref_addr) < MAX_L) ? rmem[int'(bus.ref_addr)] : SYM_A;
  end

  // PE chain: holds what the sequencer stored, scores each streamed column, N cycles of latency.
  sym_t              pe_q [NUM_PE];
  sym_t              pe_r [MAX_L];
  int                pe_col;
  int                pe_sc;
  bit                pe_prev_init;
  logic [NUM_PE-1:0] pipe_vld;
  logic [WIDTH-1:0]  pipe_sc [NUM_PE];

  assign bus.init_last = pipe_vld[NUM_PE-1];
  assign bus.v_last    = pipe_sc[NUM_PE-1];

  always @(posedge clk) begin
    pe_sc = 0;
    if (rst) begin
      pipe_vld <= '0;
      for (int i = 0; i < NUM_PE; i++) pipe_sc[i] <= '0;
      pe_prev_init = 1'b0;
      pe_col = 0;
    end else begin
      for (int i = 0; i < NUM_PE; i++) if (bus.store_s_en[i]) pe_q[i] = bus.s_data;
      if (bus.init_in) begin
        if (!pe_prev_init) pe_col = 0;
        if (pe_col < MAX_L) begin
          pe_r[pe_col] = bus.t_in;
          pe_sc = last_row_score(pe_q, pe_r, pe_col);
        end
        pe_col++;
      end
      pe_prev_init = bus.init_in;
      pipe_vld   <= {pipe_vld[NUM_PE-2:0], bus.init_in};
      pipe_sc[0] <= WIDTH'(pe_sc);
      for (int i = 1; i < NUM_PE; i++) pipe_sc[i] <= pipe_sc[i-1];
    end
  end

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("[TB] FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic check_all_zero(input string where);
    checkOutput({where, " q_rd_en"},    32'(bus.q_rd_en), 0);
    checkOutput({where, " q_addr"},     32'(bus.q_addr), 0);
    checkOutput({where, " ref_rd_en"},  32'(bus.ref_rd_en), 0);
    checkOutput({where, " ref_addr"},   32'(bus.ref_addr), 0);
    checkOutput({where, " s_data"},     32'(bus.s_data), 0);
    checkOutput({where, " store_s_en"}, 32'(bus.store_s_en), 0);
    checkOutput({where, " t_in"},       32'(bus.t_in), 0);
    checkOutput({where, " init_in"},    32'(bus.init_in), 0);
    checkOutput({where, " busy"},       32'(bus.busy), 0);
    checkOutput({where, " done"},       32'(bus.done), 0);
    checkOutput({where, " best_score"}, 32'(bus.best_score), 0);
    checkOutput({where, " best_pos"},   32'(bus.best_pos), 0);
  endtask

  task automatic set_seq(input string qs, input string rs);
    for (int i = 0; i < NUM_PE; i++) qmem[i] = to_sym(qs[i]);
    for (int j = 0; j < rs.len(); j++) rmem[j] = to_sym(rs[j]);
  endtask

  // Runs one job cycle by cycle against the documented schedule (cycle 0 = edge sampling start).
  task automatic applyStimulus(input int len, input int exp_sc, input int exp_pos,
                               input int rst_cyc, input bit poke_start);
    int  n, exp_done, dones;
    bit  in_load, in_write, in_stream, in_init;
    n        = NUM_PE;
    exp_done = (len == 0) ? 1 : 2 * n + len + 2;
    dones    = 0;
    @(negedge clk);
    bus.start   = 1'b1;
    bus.ref_len = LEN_W'(len);
    @(posedge clk);
    #1;
    bus.start   = 1'b0;
    bus.ref_len = LEN_W'($urandom_range(30, 1));
    for (int c = 1; c <= exp_done + 3; c++) begin
      @(negedge clk);
      if (rst_cyc > 0 && c == rst_cyc + 1) begin
        check_all_zero("after_rst");
        rst = 1'b0;
        return;
      end
      in_load   = (len != 0) && (c <= n);
      in_write  = (len != 0) && (c >= 2) && (c <= n + 1);
      in_stream = (len != 0) && (c >= n + 1) && (c <= n + len);
      in_init   = (len != 0) && (c >= n + 2) && (c <= n + len + 1);
      checkOutput("q_rd_en", 32'(bus.q_rd_en), 32'(in_load));
      if (in_load) checkOutput("q_addr", 32'(bus.q_addr), 32'(c - 1));
      checkOutput("store_s_en", 32'(bus.store_s_en), in_write ? (32'd1 << (c - 2)) : 32'd0);
      checkOutput("ref_rd_en", 32'(bus.ref_rd_en), 32'(in_stream));
      if (in_stream) checkOutput("ref_addr", 32'(bus.ref_addr), 32'(c - n - 1));
      checkOutput("init_in", 32'(bus.init_in), 32'(in_init));
      checkOutput("busy", 32'(bus.busy), 32'(c <= exp_done));
      checkOutput("done", 32'(bus.done), 32'(c == exp_done));
      if (bus.done) begin
        dones++;
        checkOutput("best_score", 32'(bus.best_score), 32'(exp_sc));
        checkOutput("best_pos", 32'(bus.best_pos), 32'(exp_pos));
      end
      if (c == rst_cyc) rst = 1'b1;
      bus.start = poke_start && (c == 3 || c == 10);
    end
    bus.start = 1'b0;
    checkOutput("done_count", 32'(dones), 1);
    checkOutput("held_score", 32'(bus.best_score), 32'(exp_sc));
    checkOutput("held_pos", 32'(bus.best_pos), 32'(exp_pos));
  endtask

  initial begin
    int len, best, pos, sc, off;
    bus.start   = 1'b0;
    bus.ref_len = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check_all_zero("reset");
    rst = 1'b0;

    set_seq("ACGT", "ACGT");
    applyStimulus(4, 8, 3, 0, 1'b0);
    set_seq("ACGT", "TTACGTAA");
    applyStimulus(8, 8, 5, 0, 1'b0);
    set_seq("AAAA", "CCCCCC");
    applyStimulus(6, 0, 0, 0, 1'b0);
    applyStimulus(0, 0, 0, 0, 1'b0);
    set_seq("ACGT", "TTACGTAA");
    applyStimulus(8, 0, 0, 8, 1'b0);
    set_seq("ACGT", "ACGT");
    applyStimulus(4, 8, 3, 0, 1'b0);
    set_seq("ACGT", "TTACGTAA");
    applyStimulus(8, 8, 5, 0, 1'b1);

    for (int t = 0; t < 25; t++) begin
      len = $urandom_range(24, 1);
      for (int i = 0; i < NUM_PE; i++) qmem[i] = sym_t'($urandom_range(3, 0));
      for (int j = 0; j < MAX_L; j++) rmem[j] = sym_t'($urandom_range(3, 0));
      if (len >= NUM_PE && $urandom_range(1, 0) == 1) begin
        off = $urandom_range(len - NUM_PE, 0);
        for (int i = 0; i < NUM_PE; i++) rmem[off + i] = qmem[i];
      end
      best = 0;
      pos  = 0;
      for (int k = 0; k < len; k++) begin
        sc = last_row_score(qmem, rmem, k);
        if (sc > best) begin
          best = sc;
          pos  = k;
        end
      end
      applyStimulus(len, best, pos, 0, t[0]);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
